cpu_hazard_forward_unit: RTL and testbench
==========================================

# cpu_hazard_forward_unit

Pipeline interlock block for the five-stage core (fetch, decode, execute, commit, writeback). It combines the forwarding unit and the hazard-detection unit. The forwarding logic selects bypass sources for the decode-stage register read and the execute-stage ALU operands. The hazard logic raises the load-use stall, the bubble (nop) and the branch flush, and counts stall cycles for debug.

## Interface
- No parameters. Register index width is 5 bits (32 registers); r0 is hardwired zero.
- clock  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-low.
- dec_ra, dec_rb  in  5 each  source registers of the instruction in decode.
- dec_use_ra, dec_use_rb  in  1 each  decode instruction actually reads ra / rb.
- ex_ra, ex_rb  in  5 each  source registers of the instruction in execute.
- ex_use_ra, ex_use_rb  in  1 each  execute instruction reads ra / rb.
- ex_rd  in  5  destination of the execute instruction.
- ex_reg_write  in  1  execute instruction writes a register.
- ex_mem_read  in  1  execute instruction is a load.
- ex_branch_taken  in  1  branch or jump resolved taken in execute.
- cm_rd, cm_reg_write  in  5, 1  destination and write enable in commit.
- wb_rd, wb_reg_write  in  5, 1  destination and write enable in writeback.
- ra_execute_bypass, rb_execute_bypass  out  2 each  0 = register/pipeline value, 1 = commit ALU result, 2 = writeback data. Encoding 3 is never driven.
- ra_decode_bypass, rb_decode_bypass  out  1 each  1 = take the writeback data instead of the register-file read.
- stall  out  1  hold PC and the fetch→decode register.
- nop  out  1  insert a bubble into the decode→execute register.
- flush  out  1  kill the instructions in fetch→decode and decode→execute.
- stall_cycles  out  16  saturating count of cycles with stall=1.

## Operation
- **Match rule.** A producer P "matches" source register s when all three hold: P.reg_write=1, P.rd==s, and s≠0. The consumer's use flag must also be 1.
- **Execute bypass, per operand.**
  - A commit match gives 1.
  - Otherwise a writeback match gives 2.
  - Otherwise 0.
  - Commit has priority because it holds the youngest value.
- **Decode bypass, per operand.** The output is 1 iff writeback matches the decode source. The register-file write and read happen in the same cycle, so the value being written is forwarded.
- **Load-use hazard.** Raised when ex_mem_read=1, ex_reg_write=1, ex_rd≠0, and ex_rd equals dec_ra (with dec_use_ra=1) or dec_rb (with dec_use_rb=1). It drives stall=1 and nop=1.
- **Branch.** ex_branch_taken=1 drives flush=1 and nop=1, and forces stall=0. Flush overrides a simultaneous load-use hazard, because the dependent instruction is discarded.
- **ALU-to-ALU dependencies** never stall; they are resolved by the execute bypass.
- **Stall counter.**
  - stall_cycles increments on each rising clock edge with stall=1.
  - It saturates at 16'hFFFF.
  - Only reset clears it.

## Timing
- All bypass, stall, nop and flush outputs are combinational from the current-cycle inputs, with zero latency.
- A load-use stall lasts exactly one cycle. The load advances to commit on the next edge, and the hazard clears once the dependent instruction takes the commit/writeback bypass.
- While reset=0, all outputs read 0 asynchronously and stall_cycles is forced to 0.
- After reset deasserts, the counter resumes counting from the first rising edge.
- If reset asserts mid-stall, stall drops immediately.

## Test plan
- **Commit forward.** Commit holds ADD r1 (cm_rd=1, cm_reg_write=1); execute holds an instruction with ex_ra=1, ex_use_ra=1. Required: ra_execute_bypass=1, rb_execute_bypass=0, stall=0.
- **Priority and r0.**
  - cm_rd=wb_rd=3, both writing; ex_rb=3 used. Required: rb_execute_bypass=1.
  - Then set cm_reg_write=0. Required: 2.
  - Then set ex_rb=0 with both producers writing r0. Required: 0.
- **Decode bypass.** wb_rd=2, wb_reg_write=1; dec_ra=2, dec_rb=5, both used. Required: ra_decode_bypass=1, rb_decode_bypass=0.
- **Load-use.**
  - Load in execute (ex_mem_read=1, ex_rd=4); decode reads rb=4. Required: stall=1, nop=1 for one cycle, stall_cycles goes 0→1.
  - Next cycle, with the load in commit and ex_rb=4. Required: stall=0, rb_execute_bypass=1.
- **Flush priority.** Same load-use setup with ex_branch_taken=1. Required: flush=1, nop=1, stall=0, and the counter unchanged.
- **Reset and saturation.**
  - Hold stall=1 for 70000 cycles. Required: stall_cycles=FFFF.
  - Pulse reset low asynchronously. Required: all outputs 0 immediately.

Source files
------------

// File: rtl/cpu_hazard_forward_unit.sv
// Forwarding and hazard-detection interlock for the five-stage core.
// Bypass/stall/nop/flush are combinational; stall_cycles is a saturating debug counter.
module cpu_hazard_forward_unit (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  dec_ra,
  input  logic [4:0]  dec_rb,
  input  logic        dec_use_ra,
  input  logic        dec_use_rb,
  input  logic [4:0]  ex_ra,
  input  logic [4:0]  ex_rb,
  input  logic        ex_use_ra,
  input  logic        ex_use_rb,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  input  logic        ex_mem_read,
  input  logic        ex_branch_taken,
  input  logic [4:0]  cm_rd,
  input  logic        cm_reg_write,
  input  logic [4:0]  wb_rd,
  input  logic        wb_reg_write,
  output logic [1:0]  ra_execute_bypass,
  output logic [1:0]  rb_execute_bypass,
  output logic        ra_decode_bypass,
  output logic        rb_decode_bypass,
  output logic        stall,
  output logic        nop,
  output logic        flush,
  output logic [15:0] stall_cycles
);

  function automatic logic match(input logic we, input logic [4:0] rd,
                                 input logic [4:0] src, input logic use_src);
    return we && use_src && (rd == src) && (src != 5'd0);
  endfunction

  function automatic logic [1:0] ex_sel(input logic [4:0] src, input logic use_src,
                                        input logic [4:0] c_rd, input logic c_we,
                                        input logic [4:0] w_rd, input logic w_we);
    if (match(c_we, c_rd, src, use_src))
      return 2'd1;
    else if (match(w_we, w_rd, src, use_src))
      return 2'd2;
    else
      return 2'd0;
  endfunction

  logic load_use;

  // All combinational outputs are held at zero while reset is asserted.
  always_comb begin
    ra_execute_bypass = '0;
    rb_execute_bypass = '0;
    ra_decode_bypass  = 1'b0;
    rb_decode_bypass  = 1'b0;
    stall             = 1'b0;
    nop               = 1'b0;
    flush             = 1'b0;
    load_use          = 1'b0;
    if (reset) begin
      ra_execute_bypass = ex_sel(ex_ra, ex_use_ra, cm_rd, cm_reg_write, wb_rd, wb_reg_write);
      rb_execute_bypass = ex_sel(ex_rb, ex_use_rb, cm_rd, cm_reg_write, wb_rd, wb_reg_write);
      ra_decode_bypass  = match(wb_reg_write, wb_rd, dec_ra, dec_use_ra);
      rb_decode_bypass  = match(wb_reg_write, wb_rd, dec_rb, dec_use_rb);
      load_use = ex_mem_read &&
                 (match(ex_reg_write, ex_rd, dec_ra, dec_use_ra) ||
                  match(ex_reg_write, ex_rd, dec_rb, dec_use_rb));
      // A taken branch discards the dependent instruction, so it wins over load-use.
      if (ex_branch_taken) begin
        flush = 1'b1;
        nop   = 1'b1;
      end else if (load_use) begin
        stall = 1'b1;
        nop   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      stall_cycles <= '0;
    else if (stall && (stall_cycles != '1))
      stall_cycles <= stall_cycles + 16'd1;
  end

endmodule

// File: tb/tb_cpu_hazard_forward_unit.sv
// Directed bench for cpu_hazard_forward_unit with hand-computed expectations.
module tb_cpu_hazard_forward_unit;
  logic        clock;
  logic        reset;
  logic [4:0]  dec_ra, dec_rb, ex_ra, ex_rb, ex_rd, cm_rd, wb_rd;
  logic        dec_use_ra, dec_use_rb, ex_use_ra, ex_use_rb;
  logic        ex_reg_write, ex_mem_read, ex_branch_taken, cm_reg_write, wb_reg_write;
  logic [1:0]  ra_execute_bypass, rb_execute_bypass;
  logic        ra_decode_bypass, rb_decode_bypass, stall, nop, flush;
  logic [15:0] stall_cycles;

  int unsigned tests = 0;
  int unsigned fails = 0;

  cpu_hazard_forward_unit dut (
    .clock(clock), .reset(reset),
    .dec_ra(dec_ra), .dec_rb(dec_rb), .dec_use_ra(dec_use_ra), .dec_use_rb(dec_use_rb),
    .ex_ra(ex_ra), .ex_rb(ex_rb), .ex_use_ra(ex_use_ra), .ex_use_rb(ex_use_rb),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_branch_taken(ex_branch_taken),
    .cm_rd(cm_rd), .cm_reg_write(cm_reg_write), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
    .ra_execute_bypass(ra_execute_bypass), .rb_execute_bypass(rb_execute_bypass),
    .ra_decode_bypass(ra_decode_bypass), .rb_decode_bypass(rb_decode_bypass),
    .stall(stall), .nop(nop), .flush(flush), .stall_cycles(stall_cycles)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    dec_ra = '0; dec_rb = '0; dec_use_ra = 1'b0; dec_use_rb = 1'b0;
    ex_ra = '0; ex_rb = '0; ex_use_ra = 1'b0; ex_use_rb = 1'b0;
    ex_rd = '0; ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_branch_taken = 1'b0;
    cm_rd = '0; cm_reg_write = 1'b0; wb_rd = '0; wb_reg_write = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_raex"}, {14'd0, ra_execute_bypass}, 16'd0);
    check({tag, "_rbex"}, {14'd0, rb_execute_bypass}, 16'd0);
    check({tag, "_dec"},  {14'd0, ra_decode_bypass, rb_decode_bypass}, 16'd0);
    check({tag, "_snf"},  {13'd0, stall, nop, flush}, 16'd0);
    check({tag, "_cnt"},  stall_cycles, 16'd0);
  endtask

  task automatic set_load_use();
    clear_inputs();
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd4;
    dec_ra = 5'd7; dec_use_ra = 1'b1; dec_rb = 5'd4; dec_use_rb = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    // Reset state, with inputs that would otherwise bypass and stall.
    wb_rd = 5'd2; wb_reg_write = 1'b1; dec_ra = 5'd2; dec_use_ra = 1'b1;
    ex_mem_read = 1'b1; ex_reg_write = 1'b1; ex_rd = 5'd2;
    #12;
    check_all_zero("reset");
    @(negedge clock);
    clear_inputs();
    reset = 1'b1;

    // Commit forward.
    @(negedge clock);
    cm_rd = 5'd1; cm_reg_write = 1'b1; ex_ra = 5'd1; ex_use_ra = 1'b1;
    #1;
    check("cm_fwd_ra", {14'd0, ra_execute_bypass}, 16'd1);
    check("cm_fwd_rb", {14'd0, rb_execute_bypass}, 16'd0);
    check("cm_fwd_stall", {15'd0, stall}, 16'd0);

    // Priority and r0.
    @(negedge clock);
    clear_inputs();
    cm_rd = 5'd3; cm_reg_write = 1'b1; wb_rd = 5'd3; wb_reg_write = 1'b1;
    ex_rb = 5'd3; ex_use_rb = 1'b1;
    #1 check("prio_cm", {14'd0, rb_execute_bypass}, 16'd1);
    cm_reg_write = 1'b0;
    #1 check("prio_wb", {14'd0, rb_execute_bypass}, 16'd2);
    cm_reg_write = 1'b1; cm_rd = 5'd0; wb_rd = 5'd0; ex_rb = 5'd0;
    #1 check("prio_r0", {14'd0, rb_execute_bypass}, 16'd0);
    ex_rb = 5'd3; cm_rd = 5'd3; wb_rd = 5'd3; ex_use_rb = 1'b0;
    #1 check("unused_rb", {14'd0, rb_execute_bypass}, 16'd0);

    // Decode bypass.
    @(negedge clock);
    clear_inputs();
    wb_rd = 5'd2; wb_reg_write = 1'b1;
    dec_ra = 5'd2; dec_rb = 5'd5; dec_use_ra = 1'b1; dec_use_rb = 1'b1;
    #1;
    check("dec_ra", {15'd0, ra_decode_bypass}, 16'd1);
    check("dec_rb", {15'd0, rb_decode_bypass}, 16'd0);

    // ALU-to-ALU dependency never stalls.
    @(negedge clock);
    clear_inputs();
    ex_reg_write = 1'b1; ex_rd = 5'd6; dec_ra = 5'd6; dec_use_ra = 1'b1;
    #1 check("alu_nostall", {13'd0, stall, nop, flush}, 16'd0);

    // Load-use.
    @(negedge clock);
    set_load_use();
    #1;
    check("lu_stall_nop", {14'd0, stall, nop}, 16'd3);
    check("lu_flush", {15'd0, flush}, 16'd0);
    check("lu_cnt0", stall_cycles, 16'd0);
    @(posedge clock);
    #1 check("lu_cnt1", stall_cycles, 16'd1);
    @(negedge clock);
    clear_inputs();
    cm_rd = 5'd4; cm_reg_write = 1'b1; ex_rb = 5'd4; ex_use_rb = 1'b1;
    dec_ra = 5'd8; dec_use_ra = 1'b1;
    #1;
    check("lu_next_stall", {15'd0, stall}, 16'd0);
    check("lu_next_byp", {14'd0, rb_execute_bypass}, 16'd1);
    @(posedge clock);
    #1 check("lu_next_cnt", stall_cycles, 16'd1);

    // Flush priority over load-use.
    @(negedge clock);
    set_load_use();
    ex_branch_taken = 1'b1;
    #1 check("fl_snf", {13'd0, stall, nop, flush}, 16'd3);
    @(posedge clock);
    #1 check("fl_cnt", stall_cycles, 16'd1);

    // Saturation: counter starts at 1, 70000 stalled edges push past FFFF.
    @(negedge clock);
    set_load_use();
    repeat (70000) @(posedge clock);
    #1 check("sat_cnt", stall_cycles, 16'hFFFF);
    @(posedge clock);
    #1 check("sat_hold", stall_cycles, 16'hFFFF);

    // Asynchronous reset mid-stall, away from any clock edge.
    #2 reset = 1'b0;
    #1 check_all_zero("areset");
    @(negedge clock);
    reset = 1'b1;
    #1 check("rel_stall", {15'd0, stall}, 16'd1);
    check("rel_cnt0", stall_cycles, 16'd0);
    @(posedge clock);
    #1 check("rel_cnt1", stall_cycles, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
